// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 keyboard receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0]  PS2_BREAK      = 8'hF0;
    localparam logic [7:0]  PS2_EXTEND     = 8'hE0;
    localparam int unsigned PS2_FRAME_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : First-word-fall-through scancode FIFO; head reads 0 when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q;
    logic                       do_push;
    logic                       do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == {1'b1, {FIFO_DEPTH_LOG2{1'b0}}});
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_rx
// Description : PS/2 device-to-host frame receiver with scancode FIFO.
//               Optional break-code filtering with macro PS2_BREAK_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx #(
    parameter int FILTER_WIDTH    = 4,
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int TIMEOUT_WIDTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       FLAG_read,
    output logic [7:0] key_data,
    output logic       key_valid,
    output logic       frame_error,
    output logic       overflow
);

    import ps2_pkg::*;

    localparam int FCW = $clog2(FILTER_WIDTH + 1);
    localparam int BCW = $clog2(PS2_FRAME_BITS);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_WIDTH - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(PS2_FRAME_BITS - 1);

    logic                     clk_meta_q, clk_sync_q;
    logic                     data_meta_q, data_sync_q;
    logic                     filt_q, filt_d;
    logic [FCW-1:0]           filt_cnt_q, filt_cnt_d;
    ps2_state_e               state_q, state_d;
    logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]               shift_q, shift_d;
    logic                     parity_q, parity_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic                     frame_error_q, overflow_q, overflow_d;
    logic                     fall_tick, wd_expire, byte_done, frame_bad, push_req;
    logic                     fifo_empty, fifo_full;

    // The filtered level flips on the FILTER_WIDTH-th consecutive differing sample.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall_tick = filt_q & ~filt_d;
    assign wd_expire = (state_q != IDLE) && !fall_tick && (&wd_q);
    assign wd_d      = ((state_q == IDLE) || fall_tick) ? '0 : wd_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        if (wd_expire) begin
            state_d   = IDLE;
            frame_bad = 1'b1;
        end else if (fall_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data_sync_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_sync_q && ((^shift_q) ^ parity_q)) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic brk_q, brk_d;

    // Swallow the break prefix and the key code that follows it.
    always_comb begin
        brk_d    = brk_q;
        push_req = 1'b0;
        if (byte_done) begin
            if (shift_q == PS2_EXTEND) begin
                push_req = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
            end else if (shift_q == PS2_BREAK) begin
                brk_d = 1'b1;
            end else begin
                push_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            brk_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
        end
    end
`else
    assign push_req = byte_done;
`endif

    assign overflow_d = overflow_q | (push_req & fifo_full & ~(FLAG_read & ~fifo_empty));

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_meta_q    <= 1'b1;
            clk_sync_q    <= 1'b1;
            data_meta_q   <= 1'b1;
            data_sync_q   <= 1'b1;
            filt_q        <= 1'b1;
            filt_cnt_q    <= '0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            wd_q          <= '0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            clk_meta_q    <= ps2_clk;
            clk_sync_q    <= clk_meta_q;
            data_meta_q   <= ps2_data;
            data_sync_q   <= data_meta_q;
            filt_q        <= filt_d;
            filt_cnt_q    <= filt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            wd_q          <= wd_d;
            frame_error_q <= frame_bad;
            overflow_q    <= overflow_d;
        end
    end

    ps2_rx_fifo #(
        .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (shift_q),
        .pop       (FLAG_read),
        .head      (key_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign key_valid   = ~fifo_empty;
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keyboard_rx
// Description : Self-checking bench: queue-level scoreboard plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;

    localparam int FW     = 4;
    localparam int FDL    = 3;
    localparam int TW     = 10;
    localparam int DEPTH  = 1 << FDL;
    localparam int H      = 20;
    // two synchroniser flops, FW filter samples, then the full watchdog span
    localparam int TO_LAT = 2 + FW + (1 << TW);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       FLAG_read = 1'b0;
    logic [7:0] key_data;
    logic       key_valid, frame_error, overflow;

    ps2_keyboard_rx #(
        .FILTER_WIDTH    (FW),
        .FIFO_DEPTH_LOG2 (FDL),
        .TIMEOUT_WIDTH   (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .FLAG_read   (FLAG_read),
        .key_data    (key_data),
        .key_valid   (key_valid),
        .frame_error (frame_error),
        .overflow    (overflow)
    );

    always #10 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned last_fall = 0;
    int unsigned err_cyc = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    bit          fe_prev = 1'b0;
    bit          busy = 1'b1;
    logic [7:0]  mq[$];
    bit          m_ovf = 1'b0;
    bit          m_brk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (frame_error) begin
            err_seen++;
            err_cyc = cyc;
            chk("fe_pulse_width", {31'd0, fe_prev}, 32'd0);
        end
        fe_prev = frame_error;
        if (!busy && reset) begin
            chk("key_valid", {31'd0, key_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) chk("key_data", {24'd0, key_data}, {24'd0, mq[0]});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    task automatic model_byte(input logic [7:0] b, input bit good, input bit with_pop);
        if (with_pop && mq.size() != 0) void'(mq.pop_front());
        if (!good) begin
            exp_err++;
            return;
        end
`ifdef PS2_BREAK_FILTER_EN
        if (b != 8'hE0) begin
            if (m_brk) begin
                m_brk = 1'b0;
                return;
            end
            if (b == 8'hF0) begin
                m_brk = 1'b1;
                return;
            end
        end
`endif
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic d);
        ps2_data = d;
        wait_cyc(H / 2);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        wait_cyc(H);
        ps2_clk = 1'b1;
        wait_cyc(H / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit with_pop);
        busy = 1'b1;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_data = 1'b1;
        wait_cyc(H / 2);
        ps2_clk = 1'b0;
        if (with_pop) begin
            wait_cyc(2 + FW - 1);
            FLAG_read = 1'b1;
            wait_cyc(1);
            FLAG_read = 1'b0;
            wait_cyc(H - (2 + FW));
        end else begin
            wait_cyc(H);
        end
        ps2_clk = 1'b1;
        wait_cyc(H / 2);
        model_byte(b, !bad_par, with_pop);
        busy = 1'b0;
        wait_cyc(H);
    endtask

    task automatic read_pop();
        busy = 1'b1;
        FLAG_read = 1'b1;
        wait_cyc(1);
        FLAG_read = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        busy = 1'b0;
        wait_cyc(1);
    endtask

    task automatic read_expect(input string name, input logic [7:0] exp);
        chk(name, {23'd0, key_valid, key_data}, {23'd0, 1'b1, exp});
        read_pop();
    endtask

    task automatic do_reset();
        busy = 1'b1;
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_brk = 1'b0;
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_data", {24'd0, key_data}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_frame_error", {31'd0, frame_error}, 32'd0);
        busy = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        int e0;
        logic [7:0] b;
        wait_cyc(3);
        do_reset();
        wait_cyc(5);

        // single good frame, then pop
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("good_1c_data", {23'd0, key_valid, key_data}, {23'd0, 1'b1, 8'h1C});
        chk("good_1c_no_err", err_seen, 0);
        read_pop();
        chk("good_1c_popped", {31'd0, key_valid}, 32'd0);

        // parity error, then recovery
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("bad_par_err", err_seen, 1);
        chk("bad_par_valid", {31'd0, key_valid}, 32'd0);
        send_frame(8'h32, 1'b0, 1'b0);
        read_expect("good_32", 8'h32);
        read_pop();
        chk("empty_read_ignored", {30'd0, key_valid, overflow}, 32'd0);

        // nine frames with no reads overflow an eight-deep FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 1; i <= 8; i++) read_expect("ovf_drain", 8'(i));
        chk("ovf_drained", {30'd0, key_valid, overflow}, 32'd1);

        // push and pop together while full
        for (int i = 1; i <= 8; i++) send_frame(8'hA0 + 8'(i), 1'b0, 1'b0);
        send_frame(8'hA9, 1'b0, 1'b1);
        for (int i = 2; i <= 9; i++) read_expect("full_pushpop", 8'hA0 + 8'(i));
        chk("full_pushpop_empty", {31'd0, key_valid}, 32'd0);

        // push and pop together with one entry held
        send_frame(8'h44, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1);
        read_expect("one_pushpop", 8'h55);

        // partial frame stalls: watchdog abort
        e0 = err_seen;
        b = 8'h1C;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        exp_err++;
        for (int k = 0; k < 2 * TO_LAT && err_seen == e0; k++) wait_cyc(1);
        chk("timeout_err", err_seen, e0 + 1);
        chk("timeout_latency", err_cyc - last_fall, TO_LAT);
        send_frame(8'h1C, 1'b0, 1'b0);
        read_expect("after_timeout", 8'h1C);

        // reset in mid-frame with bytes queued
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        m_ovf = 1'b1;
        chk("pre_reset_state", {30'd0, key_valid, overflow}, 32'd3);
        b = 8'hFF;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(b[i]);
        do_reset();
        for (int i = 5; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b);
        ps2_bit(1'b1);
        wait_cyc(2 * TO_LAT);
        chk("reset_rest_no_byte", {31'd0, key_valid}, 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0);
        read_expect("after_reset", 8'h1C);

        // break-code sequence
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        read_expect("brk_seq0", 8'h1C);
`ifndef PS2_BREAK_FILTER_EN
        read_expect("brk_seq1", 8'hF0);
        read_expect("brk_seq2", 8'h1C);
`endif
        chk("brk_seq_end", {31'd0, key_valid}, 32'd0);

        chk("frame_error_count", err_seen, exp_err);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20_000_000;
        errors++;
        $display("FAIL global_timeout: simulation exceeded its time budget at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time budget exceeded");
    end

endmodule
`default_nettype wire
